vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive side of the VGA timing interface. Takes sync, blank and 8-bit RGB streams in the pixel clock domain and recovers pixel coordinates.
- Measures line length and lines per frame, and reports lock once timing is stable.
- Sits behind a video source (loopback of our own timing generator, or an external capture front end). Feeds frame-buffer write logic and test checkers.

Parameters:
- H_MAX, 1023: saturation limit of the clocks-per-line counter; a line reaching it is invalid.
- V_MAX, 1023: saturation limit of the lines-per-frame counter.
- LOSS_TIMEOUT, 1023: clocks with no hs falling edge before lock is dropped.

Ports:
- clk_25m  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_hs  in  1  horizontal sync, active-low.
- in_vs  in  1  vertical sync, active-low.
- in_de  in  1  display enable (high = active pixel; same polarity as our vga_blank).
- in_r, in_g, in_b  in  8 each  pixel colour.
- x  out  10  column of the current output pixel.
- y  out  10  row of the current output pixel.
- pix_valid  out  1  output pixel is active video.
- pix_r, pix_g, pix_b  out  8 each  colour aligned with x/y.
- frame_start  out  1  one-cycle pulse at frame boundary.
- h_total  out  10  last measured clocks per line.
- v_total  out  10  last measured lines per frame.
- locked  out  1  timing stable.
- err_cnt  out  8  saturating count of lock losses.

Behaviour:
- Reset: all outputs and internal state are 0; FSM goes to SEARCH.
- Stage 1: register all inputs. Edge detects (hs_fall, vs_fall, de_rise, de_fall) compare stage 1 against a second registered copy.
- Stage 2 produces x, y, pix_*, pix_valid and frame_start. Input-to-output latency is exactly 2 clocks.
- Line measurement:
  - h_meas increments every clock and saturates at H_MAX.
  - On hs_fall: h_total <= h_meas+1 (or H_MAX if saturated), h_meas <= 0, and v_meas increments (saturating at V_MAX).
- Frame measurement:
  - On vs_fall: v_total <= v_meas (including a line ended by an hs_fall in the same cycle), v_meas <= 0.
  - frame_start pulses on the corresponding stage-2 cycle.
- Pixel coordinates:
  - x = 0 on the first de-high pixel of a line, +1 per de-high pixel, held when de is low.
  - x resets on the next de_rise and saturates at 1023.
  - y increments on each de_fall and resets to 0 on vs_fall.
  - pix_valid = de delayed 2 clocks. pix_* always pass through with 2-clock delay, even when not valid.
- Lock FSM:
  - SEARCH: locked=0. On vs_fall -> MEASURE (the partial frame is discarded).
  - MEASURE: on vs_fall, latch h_ref=h_total and v_ref=v_total -> CHECK.
  - CHECK: on each hs_fall, compare h_total to h_ref. On vs_fall, if every line matched h_ref, v_total==v_ref, and both are nonzero and unsaturated -> LOCKED. Otherwise re-latch the refs and stay in CHECK.
  - LOCKED: locked=1. Any hs_fall with h_total!=h_ref, or vs_fall with v_total!=v_ref -> MEASURE, locked=0 next cycle, err_cnt +1 (saturating at 255).
  - Timeout: no hs_fall for LOSS_TIMEOUT clocks in any state -> SEARCH, locked=0. Counts as a loss (err_cnt +1) only if leaving LOCKED.
- Simultaneous events:
  - hs_fall and vs_fall in one cycle: apply the line update first, then the frame update.
  - de_fall and vs_fall in one cycle: vs_fall wins, y=0.
- Reset mid-frame: everything clears asynchronously. After release, decoding resumes from SEARCH and needs at least 2 full frames to re-lock.

Test Plan:
- Standard timing (800 clk/line, hs low clks 656-751, de on clks 0-639 of lines 0-479, 525 lines): after 3 frames h_total=800, v_total=525, locked=1. Each frame ends with x=639, y=480, and exactly 307200 pix_valid cycles.
- Latency: single de-high pixel with r=0xA5 at cycle n -> pix_valid=1, pix_r=0xA5, x=0 at cycle n+2 exactly.
- Glitch: while locked, one line shortened to 799 clocks -> locked=0 on the following cycle, err_cnt=1. Re-lock after 2 clean frames.
- Timeout: hold in_hs=1 for 1100 clocks while locked -> locked=0, err_cnt=1, FSM in SEARCH. Restoring timing locks after 3 vs_falls.
- Simultaneous edges: hs_fall and vs_fall in the same cycle on a 10-line synthetic frame -> v_total=10 and frame_start pulses once.
- Async reset asserted mid-line with locked=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing decoder: recovers pixel coordinates,
// measures line/frame length and tracks timing lock.
module vga_sync_decoder #(
    parameter int H_MAX        = 1023,
    parameter int V_MAX        = 1023,
    parameter int LOSS_TIMEOUT = 1023
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic       in_de,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_valid,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       frame_start,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam logic [9:0] HMAX = 10'(H_MAX);
    localparam logic [9:0] VMAX = 10'(V_MAX);
    localparam int TW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(LOSS_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        CHECK,
        LOCKED
    } state_t;

    state_t state;

    logic          hs1, vs1, de1;
    logic          hs2, vs2, de2;
    logic [7:0]    r1, g1, b1;
    logic [9:0]    h_meas, v_meas;
    logic [9:0]    h_ref, v_ref;
    logic          line_bad;
    logic [TW-1:0] to_cnt;

    logic       hs_fall, vs_fall, de_rise, de_fall;
    logic [9:0] h_line, h_cur, v_inc, v_frame;
    logic       tmo, h_bad, frame_ok;

    always_comb begin
        hs_fall = hs2 & ~hs1;
        vs_fall = vs2 & ~vs1;
        de_rise = de1 & ~de2;
        de_fall = de2 & ~de1;
        h_line  = (h_meas == HMAX) ? HMAX : h_meas + 10'd1;
        h_cur   = hs_fall ? h_line : h_total;
        v_inc   = (v_meas == VMAX) ? VMAX : v_meas + 10'd1;
        // a line closed in the same cycle as vsync belongs to this frame
        v_frame = hs_fall ? v_inc : v_meas;
        tmo     = !hs_fall && (to_cnt == TO_LAST);
        h_bad   = hs_fall && (h_line != h_ref);
        frame_ok = !line_bad && !h_bad && (v_frame == v_ref) &&
                   (h_cur != 10'd0) && (h_cur != HMAX) &&
                   (v_frame != 10'd0) && (v_frame != VMAX);
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            de1 <= 1'b0;
            hs2 <= 1'b0;
            vs2 <= 1'b0;
            de2 <= 1'b0;
            r1  <= 8'd0;
            g1  <= 8'd0;
            b1  <= 8'd0;
        end else begin
            hs1 <= in_hs;
            vs1 <= in_vs;
            de1 <= in_de;
            hs2 <= hs1;
            vs2 <= vs1;
            de2 <= de1;
            r1  <= in_r;
            g1  <= in_g;
            b1  <= in_b;
        end
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_r       <= 8'd0;
            pix_g       <= 8'd0;
            pix_b       <= 8'd0;
            frame_start <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
        end else begin
            pix_valid   <= de1;
            pix_r       <= r1;
            pix_g       <= g1;
            pix_b       <= b1;
            frame_start <= vs_fall;
            if (de_rise) begin
                x <= 10'd0;
            end else if (de1 && x != 10'h3ff) begin
                x <= x + 10'd1;
            end
            if (vs_fall) begin
                y <= 10'd0;
            end else if (de_fall) begin
                y <= y + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            h_meas  <= 10'd0;
            v_meas  <= 10'd0;
            h_total <= 10'd0;
            v_total <= 10'd0;
            to_cnt  <= '0;
        end else begin
            if (hs_fall) begin
                h_meas  <= 10'd0;
                h_total <= h_line;
                to_cnt  <= '0;
            end else begin
                if (h_meas != HMAX) h_meas <= h_meas + 10'd1;
                if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            end
            if (vs_fall) begin
                v_meas  <= 10'd0;
                v_total <= v_frame;
            end else if (hs_fall) begin
                v_meas <= v_inc;
            end
        end
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            h_ref    <= 10'd0;
            v_ref    <= 10'd0;
            line_bad <= 1'b0;
            locked   <= 1'b0;
            err_cnt  <= 8'd0;
        end else if (tmo) begin
            if (state == LOCKED && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            state  <= SEARCH;
            locked <= 1'b0;
        end else begin
            unique case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vs_fall) state <= MEASURE;
                end
                MEASURE: begin
                    locked <= 1'b0;
                    if (vs_fall) begin
                        h_ref    <= h_cur;
                        v_ref    <= v_frame;
                        line_bad <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (h_bad) line_bad <= 1'b1;
                    if (vs_fall) begin
                        line_bad <= 1'b0;
                        if (frame_ok) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            h_ref <= h_cur;
                            v_ref <= v_frame;
                        end
                    end
                end
                LOCKED: begin
                    if (h_bad || (vs_fall && v_frame != v_ref)) begin
                        state  <= MEASURE;
                        locked <= 1'b0;
                        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder: a video generator pushes
// expected pixels, a monitor pops them when pix_valid is presented.
module tb_vga_sync_decoder;

    logic       clk_25m = 1'b0;
    logic       rst;
    logic       in_hs, in_vs, in_de;
    logic [7:0] in_r, in_g, in_b;
    logic [9:0] x, y, h_total, v_total;
    logic       pix_valid, frame_start, locked;
    logic [7:0] pix_r, pix_g, pix_b, err_cnt;

    vga_sync_decoder dut (
        .clk_25m(clk_25m), .rst(rst),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .x(x), .y(y), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start),
        .h_total(h_total), .v_total(v_total),
        .locked(locked), .err_cnt(err_cnt)
    );

    always #20 clk_25m = ~clk_25m;

    int cyc = 0;
    always @(posedge clk_25m) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] r, g, b;
        logic [9:0] x, y;
    } pix_t;

    pix_t sb[$];
    int total = 0;
    int bad = 0;
    int fs_cnt = 0;

    int T_LEN, T_HSL, T_HSH, T_DEW, T_DEL0, T_DEN, T_VSP, T_VSN;
    int glitch_line = -1;
    int hold_left = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [7:0] r, input int ex, input int ey);
        pix_t e;
        in_hs = hs;
        in_vs = vs;
        in_de = de;
        in_r  = r;
        in_g  = ~r;
        in_b  = r ^ 8'h5a;
        if (de) begin
            e.cyc = cyc + 2;
            e.r = r;
            e.g = ~r;
            e.b = r ^ 8'h5a;
            e.x = 10'(ex);
            e.y = 10'(ey);
            sb.push_back(e);
        end
        @(posedge clk_25m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 0, 0);
    endtask

    task automatic run_line(input int l, input int c0, input int c1);
        int n, p;
        logic hs, vs, de;
        n = (l == glitch_line) ? T_LEN - 1 : T_LEN;
        for (int c = c0; c < c1 && c < n; c++) begin
            p  = l * T_LEN + c;
            hs = !(c >= T_HSL && c <= T_HSH);
            vs = !(p >= T_VSP && p < T_VSP + T_VSN);
            de = (c < T_DEW) && (l >= T_DEL0) && (l < T_DEL0 + T_DEN);
            if (hold_left > 0) begin
                hs = 1'b1;
                hold_left--;
            end
            drive(hs, vs, de, 8'(c * 3 + l * 7), c, l - T_DEL0);
        end
    endtask

    task automatic run_lines(input int l0, input int l1);
        for (int l = l0; l < l1; l++) run_line(l, 0, T_LEN);
    endtask

    task automatic cfg(input int len, input int hsl, input int hsh,
                       input int dew, input int del0, input int den,
                       input int vsp, input int vsn);
        T_LEN = len; T_HSL = hsl; T_HSH = hsh; T_DEW = dew;
        T_DEL0 = del0; T_DEN = den; T_VSP = vsp; T_VSN = vsn;
    endtask

    task automatic reset_pulse();
        #10 rst = 1'b1;
        #10 rst = 1'b0;
        sb.delete();
        @(posedge clk_25m);
        #1;
    endtask

    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clk_25m);
            if (!rst) begin
                if (frame_start) fs_cnt++;
                if (pix_valid) begin
                    if (sb.size() == 0) begin
                        chk("pix_unexpected", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("pix_cycle", 64'(cyc), 64'(e.cyc));
                        chk("pix_data", 64'({pix_r, pix_g, pix_b, x, y}),
                            64'({e.r, e.g, e.b, e.x, e.y}));
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    chk("pix_missing", 64'(pix_valid), 64'd1);
                end
            end
        end
    end

    initial begin
        int fs0;
        rst = 1'b1;
        in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        repeat (3) @(posedge clk_25m);
        #1;
        chk("reset_pix", 64'({x, y, pix_valid, pix_r, pix_g, pix_b, frame_start}), 64'd0);
        chk("reset_meas", 64'({h_total, v_total, locked, err_cnt}), 64'd0);
        rst = 1'b0;

        // full-size lines: 800 clocks, hsync 656-751, 640 active
        cfg(800, 656, 751, 640, 0, 3, 1 << 30, 0);
        run_lines(0, 3);
        chk("std_h_total", 64'(h_total), 64'd800);
        chk("std_x_end", 64'(x), 64'd639);
        chk("std_y_end", 64'(y), 64'd3);
        idle(5);
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 0, 3);
        idle(4);
        reset_pulse();

        // scaled frame: 50 clk/line, 40x30 active, 33 lines
        cfg(50, 41, 46, 40, 0, 30, 31 * 50, 100);
        fs0 = fs_cnt;
        for (int f = 0; f < 3; f++) begin
            run_lines(0, 31);
            chk("frame_x_end", 64'(x), 64'd39);
            chk("frame_y_end", 64'(y), 64'd30);
            run_lines(31, 33);
            if (f == 1) chk("lock_early", 64'(locked), 64'd0);
        end
        chk("lock_locked", 64'(locked), 64'd1);
        chk("lock_h_total", 64'(h_total), 64'd50);
        chk("lock_v_total", 64'(v_total), 64'd33);
        chk("lock_err", 64'(err_cnt), 64'd0);
        chk("lock_fs_cnt", 64'(fs_cnt - fs0), 64'd3);

        glitch_line = 10;
        run_lines(0, 11);
        glitch_line = -1;
        chk("glitch_before", 64'(locked), 64'd1);
        run_line(11, 0, 42);
        chk("glitch_edge", 64'(locked), 64'd1);
        run_line(11, 42, 43);
        chk("glitch_drop", 64'(locked), 64'd0);
        chk("glitch_err", 64'(err_cnt), 64'd1);
        run_line(11, 43, 50);
        run_lines(12, 33);
        chk("glitch_relock1", 64'(locked), 64'd0);
        run_lines(0, 33);
        chk("glitch_relock2", 64'(locked), 64'd1);
        chk("glitch_err2", 64'(err_cnt), 64'd1);

        run_lines(0, 5);
        hold_left = 1100;
        run_lines(5, 29);
        chk("tmo_drop", 64'(locked), 64'd0);
        chk("tmo_err", 64'(err_cnt), 64'd2);
        run_lines(29, 33);
        run_lines(0, 33);
        chk("tmo_relock2", 64'(locked), 64'd0);
        run_lines(0, 33);
        chk("tmo_relock3", 64'(locked), 64'd1);
        chk("tmo_err2", 64'(err_cnt), 64'd2);
        idle(4);
        reset_pulse();

        // 10-line frame with vsync falling together with hsync
        cfg(40, 30, 35, 20, 2, 8, 30, 80);
        run_lines(0, 10);
        fs0 = fs_cnt;
        run_lines(0, 10);
        chk("sim_fs_once", 64'(fs_cnt - fs0), 64'd1);
        chk("sim_v_total", 64'(v_total), 64'd10);
        chk("sim_h_total", 64'(h_total), 64'd40);
        run_lines(0, 10);
        chk("sim_locked", 64'(locked), 64'd1);

        run_lines(0, 2);
        run_line(2, 0, 5);
        chk("mid_locked", 64'(locked), 64'd1);
        chk("mid_x", 64'(x), 64'd3);
        #10 rst = 1'b1;
        #1;
        chk("async_pix", 64'({x, y, pix_valid, pix_r, pix_g, pix_b, frame_start}), 64'd0);
        chk("async_meas", 64'({h_total, v_total, locked, err_cnt}), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk_25m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
